// File: rtl/bubsysrom_wavegen.sv
// rtl/bubsysrom_wavegen.sv - two-channel K005289-style wavetable tone generator
// Optional mixed output enabled by defining BUBSYS_WAVE_MIX_EN.
module bubsysrom_wavegen #(
    parameter int PW = 12,
    parameter int SW = 5
) (
    input  logic        i_EMU_MCLK,
    input  logic        i_EMU_RST,
    input  logic        i_EMU_CLK3M58_PCEN,
    input  logic [11:0] i_ADDR,
    input  logic [7:0]  i_DIN,
    input  logic        i_WR_n,
    input  logic        i_WAVE1_WR,
    input  logic        i_WAVE2_WR,
    input  logic        i_WAVE1_TG,
    input  logic        i_WAVE2_TG,
    input  logic [8:0]  i_EMU_PROM_ADDR,
    input  logic [3:0]  i_EMU_PROM_DATA,
    input  logic        i_EMU_PROM_WR,
    input  logic        i_EMU_PROM_WAVE_CS,
    output logic [7:0]  o_WAVE1,
    output logic [7:0]  o_WAVE2,
    output logic [8:0]  o_WAVE_MIX
);
    localparam int AW = SW + 4;

    logic [3:0] strb;
    logic [3:0] low_q, low_d;
    logic [3:0] ev;
    logic [1:0] wr_ev, tg_ev;
    logic       unused_din;

    logic [1:0][PW-1:0] latch_q, latch_d;
    logic [1:0][PW-1:0] freq_q, freq_d;
    logic [1:0][PW-1:0] cnt_q, cnt_d;
    logic [1:0][SW-1:0] step_q, step_d;
    logic [1:0][2:0]    wsel_q, wsel_d;
    logic [1:0][3:0]    vol_q, vol_d;
    logic [1:0][7:0]    wave_q, wave_d;
    logic [1:0][4:0]    samp;
    logic [1:0][9:0]    prod;
    logic [1:0][3:0]    prom_q;
    logic [3:0]         prom_mem [2**AW];
    logic               prom_we;

    assign unused_din = i_DIN[4];
    assign strb  = {i_WAVE2_TG, i_WAVE1_TG, i_WAVE2_WR, i_WAVE1_WR} & {4{~i_WR_n}};
    // History clears low, so a strobe held through reset release must drop before it counts.
    assign low_d = ~strb;
    assign ev    = strb & low_q;
    assign wr_ev = ev[1:0];
    assign tg_ev = ev[3:2];

    always_comb begin
        latch_d = latch_q;
        freq_d  = freq_q;
        cnt_d   = cnt_q;
        step_d  = step_q;
        wsel_d  = wsel_q;
        vol_d   = vol_q;
        wave_d  = wave_q;
        samp    = '0;
        prod    = '0;
        for (int ch = 0; ch < 2; ch++) begin
            if (wr_ev[ch]) begin
                latch_d[ch] = i_ADDR[PW-1:0];
                wsel_d[ch]  = i_DIN[7:5];
                vol_d[ch]   = i_DIN[3:0];
            end
            if (tg_ev[ch]) begin
                freq_d[ch] = latch_d[ch];
            end
            if (i_EMU_CLK3M58_PCEN) begin
                if (&cnt_q[ch]) begin
                    cnt_d[ch]  = freq_d[ch];
                    step_d[ch] = step_q[ch] + 1'b1;
                end else begin
                    cnt_d[ch] = cnt_q[ch] + 1'b1;
                end
            end
            samp[ch]   = {1'b0, prom_q[ch]} - 5'd8;
            prod[ch]   = $signed({{5{samp[ch][4]}}, samp[ch]}) * $signed({6'd0, vol_q[ch]});
            wave_d[ch] = prod[ch][7:0];
        end
    end

    always_ff @(posedge i_EMU_MCLK) begin
        if (i_EMU_RST) begin
            low_q   <= '0;
            latch_q <= '0;
            freq_q  <= '0;
            cnt_q   <= '0;
            step_q  <= '0;
            wsel_q  <= '0;
            vol_q   <= '0;
            wave_q  <= '0;
        end else begin
            low_q   <= low_d;
            latch_q <= latch_d;
            freq_q  <= freq_d;
            cnt_q   <= cnt_d;
            step_q  <= step_d;
            wsel_q  <= wsel_d;
            vol_q   <= vol_d;
            wave_q  <= wave_d;
        end
    end

    // Waveform RAM survives reset; one write port, one read port per channel.
    assign prom_we = i_EMU_PROM_WAVE_CS & i_EMU_PROM_WR;

    always_ff @(posedge i_EMU_MCLK) begin
        if (prom_we) begin
            prom_mem[i_EMU_PROM_ADDR] <= i_EMU_PROM_DATA;
        end
        prom_q[0] <= prom_mem[{1'b0, wsel_q[0], step_q[0]}];
        prom_q[1] <= prom_mem[{1'b1, wsel_q[1], step_q[1]}];
    end

    assign o_WAVE1 = wave_q[0];
    assign o_WAVE2 = wave_q[1];

`ifdef BUBSYS_WAVE_MIX_EN
    logic [8:0] mix_q, mix_d;

    assign mix_d = {wave_q[0][7], wave_q[0]} + {wave_q[1][7], wave_q[1]};

    always_ff @(posedge i_EMU_MCLK) begin
        if (i_EMU_RST) begin
            mix_q <= '0;
        end else begin
            mix_q <= mix_d;
        end
    end

    assign o_WAVE_MIX = mix_q;
`else
    assign o_WAVE_MIX = '0;
`endif

endmodule

// File: tb/tb_bubsysrom_wavegen.sv
// tb/tb_bubsysrom_wavegen.sv - directed self-checking bench for bubsysrom_wavegen
module tb_bubsysrom_wavegen;
    logic        clk = 1'b0;
    logic        rst;
    logic        pcen;
    logic [11:0] addr;
    logic [7:0]  din;
    logic        wr_n;
    logic        wave1_wr, wave2_wr, wave1_tg, wave2_tg;
    logic [8:0]  prom_addr;
    logic [3:0]  prom_data;
    logic        prom_wr, prom_cs;
    logic [7:0]  wave1, wave2;
    logic [8:0]  mix;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int mix_exp;

    always #5 clk = ~clk;

    bubsysrom_wavegen dut (
        .i_EMU_MCLK         (clk),
        .i_EMU_RST          (rst),
        .i_EMU_CLK3M58_PCEN (pcen),
        .i_ADDR             (addr),
        .i_DIN              (din),
        .i_WR_n             (wr_n),
        .i_WAVE1_WR         (wave1_wr),
        .i_WAVE2_WR         (wave2_wr),
        .i_WAVE1_TG         (wave1_tg),
        .i_WAVE2_TG         (wave2_tg),
        .i_EMU_PROM_ADDR    (prom_addr),
        .i_EMU_PROM_DATA    (prom_data),
        .i_EMU_PROM_WR      (prom_wr),
        .i_EMU_PROM_WAVE_CS (prom_cs),
        .o_WAVE1            (wave1),
        .o_WAVE2            (wave2),
        .o_WAVE_MIX         (mix)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    function automatic int w1();
        return int'($signed(wave1));
    endfunction

    function automatic int w2();
        return int'($signed(wave2));
    endfunction

    function automatic int wm();
        return int'($signed(mix));
    endfunction

    task automatic prom_write(input logic [8:0] a, input logic [3:0] d);
        prom_addr = a;
        prom_data = d;
        prom_wr   = 1'b1;
        prom_cs   = 1'b1;
        tick(1);
        prom_wr   = 1'b0;
        prom_cs   = 1'b0;
    endtask

    // sel: 0 WAVE1_WR, 1 WAVE2_WR, 2 WAVE1_TG, 3 WAVE2_TG
    task automatic bus_wr(input int sel, input logic [11:0] a, input logic [7:0] d, input int hold);
        addr     = a;
        din      = d;
        wave1_wr = (sel == 0);
        wave2_wr = (sel == 1);
        wave1_tg = (sel == 2);
        wave2_tg = (sel == 3);
        wr_n     = 1'b0;
        tick(hold);
        wr_n     = 1'b1;
        wave1_wr = 1'b0;
        wave2_wr = 1'b0;
        wave1_tg = 1'b0;
        wave2_tg = 1'b0;
        tick(1);
    endtask

    task automatic wait_change(output int when, output int val);
        int prev;
        bit seen;
        prev = w1();
        seen = 1'b0;
        when = -1;
        val  = -999;
        for (int i = 0; i < 6000 && !seen; i++) begin
            tick(1);
            if (w1() != prev) begin
                seen = 1'b1;
                when = cyc;
                val  = w1();
            end
        end
    endtask

    initial begin
        int c, t0, r, when, val, nz;
        logic [4:0] kk;
`ifdef BUBSYS_WAVE_MIX_EN
        mix_exp = 210;
`else
        mix_exp = 0;
`endif
        rst = 1'b1; pcen = 1'b0; addr = '0; din = '0; wr_n = 1'b1;
        wave1_wr = 1'b0; wave2_wr = 1'b0; wave1_tg = 1'b0; wave2_tg = 1'b0;
        prom_addr = '0; prom_data = '0; prom_wr = 1'b0; prom_cs = 1'b0;
        tick(3);
        check("rst_w1", w1(), 0);
        check("rst_w2", w2(), 0);
        check("rst_mix", wm(), 0);
        rst = 1'b0;
        tick(1);

        for (int k = 0; k < 32; k++) begin
            kk = 5'(k);
            prom_write({1'b0, 3'd0, kk}, kk[4:1]);
            prom_write({1'b0, 3'd1, kk}, 4'd15 - kk[3:0]);
            prom_write({1'b0, 3'd2, kk}, 4'd15);
            prom_write({1'b1, 3'd7, kk}, 4'd15);
        end

        bus_wr(0, 12'hFF0, 8'h0F, 1);
        bus_wr(2, 12'h000, 8'h00, 1);
        tick(1);
        check("w1_step0", w1(), -120);
        check("w2_vol0", w2(), 0);

        // Counter starts at 0: first overflow after 4096 ticks, then every 16.
        pcen = 1'b1;
        c = cyc;
        for (int v = 1; v <= 16; v++) begin
            wait_change(when, val);
            check("ramp_time", when, c + 4082 + 32 * v);
            check("ramp_val", val, (v == 16) ? -120 : 15 * (v - 8));
        end
        t0 = c + 4594;

        bus_wr(0, 12'hFF0, 8'h00, 1);
        nz = 0;
        if (w1() != 0) nz++;
        for (int i = 0; i < 198; i++) begin
            tick(1);
            if (w1() != 0) nz++;
        end
        check("vol0_silent", nz, 0);
        bus_wr(0, 12'hFF0, 8'h0F, 1);
        check("vol_restore", w1(), -30);
        wait_change(when, val);
        check("step_kept_time", when, t0 + 224);
        check("step_kept_val", val, -15);

        bus_wr(0, 12'hF00, 8'h0F, 1);
        wait_change(when, val);
        check("no_tg_time", when, t0 + 256);
        check("no_tg_val", val, 0);

        tick(13);
        bus_wr(2, 12'h000, 8'h00, 1);
        wait_change(when, val);
        check("tg_ovf_time", when, t0 + 528);
        check("tg_ovf_val", val, 15);

        addr = 12'hABC; din = 8'hEF; wave2_wr = 1'b1; wr_n = 1'b0;
        tick(1);
        din = 8'hE0; addr = 12'h000;
        tick(19);
        wr_n = 1'b1; wave2_wr = 1'b0;
        tick(1);
        check("w2_single_latch", w2(), 105);
        wait_change(when, val);
        check("w1_after_w2_time", when, t0 + 1040);
        check("w1_after_w2_val", val, 30);

        rst = 1'b1; addr = 12'h000; din = 8'h2F; wave1_wr = 1'b1; wr_n = 1'b0;
        tick(1);
        r = cyc;
        check("midrst_w1", w1(), 0);
        check("midrst_w2", w2(), 0);
        check("midrst_mix", wm(), 0);
        rst = 1'b0;
        tick(3);
        check("held_no_event", w1(), 0);
        wr_n = 1'b1; wave1_wr = 1'b0;
        tick(1);
        wr_n = 1'b0; wave1_wr = 1'b1;
        tick(1);
        wr_n = 1'b1; wave1_wr = 1'b0;
        tick(2);
        check("rst_rearm", w1(), 105);
        wait_change(when, val);
        check("rst_first_step_time", when, r + 4098);
        check("rst_first_step_val", val, 90);

        bus_wr(0, 12'h000, 8'h4F, 1);
        bus_wr(1, 12'h000, 8'hEF, 1);
        tick(3);
        check("mix_w1", w1(), 105);
        check("mix_w2", w2(), 105);
        check("mix_sum", wm(), mix_exp);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
